binary_stream_adder_core: RTL and testbench
===========================================

BINARY_STREAM_ADDER_CORE -- requirements
Module: binary_stream_adder

Interface
REQ-001 Parameter WORD_LEN, default 8, number of bits per serial word (LSB first); 0 SHALL mean an unbounded stream with no word boundaries.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 A  input  1  serial operand A bit, LSB first.
REQ-005 B  input  1  serial operand B bit, LSB first.
REQ-006 Sum  output  1  serial sum bit for the current A/B bit, combinational.
REQ-007 Carry  output  1  registered carry state applied to the current bit.
REQ-008 Bit_cnt  output  8  index of the current bit within the word, registered.
REQ-009 Word_done  output  1  high while the current bit is the word's MSB, combinational.
REQ-010 Ovf  output  1  sticky word-overflow flag, registered (see Configuration).

Function
REQ-011 Sum SHALL equal A XOR B XOR Carry, with zero-cycle latency from A/B.
REQ-012 On each rising clk with rst low, Carry SHALL load majority(A, B, Carry), the carry-out of the current bit.
REQ-013 With WORD_LEN>0, Bit_cnt SHALL increment on each rising clk and wrap from WORD_LEN-1 to 0.
REQ-014 With WORD_LEN=0, Bit_cnt SHALL hold at 0.
REQ-015 With WORD_LEN>0, Word_done SHALL be high exactly when Bit_cnt equals WORD_LEN-1.
REQ-016 With WORD_LEN=0, Word_done SHALL be constant 0.
REQ-017 On a rising clk while Word_done is high, Carry SHALL load 0 instead of the carry-out, so every word starts with carry-in 0.
REQ-018 The carry-out of the MSB bit SHALL be discarded from the arithmetic; it is reported only via Ovf.
REQ-019 Inputs SHALL be sampled only at rising clk; A/B changes between edges affect only the combinational Sum.
REQ-020 There SHALL be no handshake or valid signal: every clock cycle consumes exactly one bit pair.

Reset
REQ-021 rst high SHALL immediately, without waiting for clk, force Carry=0, Bit_cnt=0 and Ovf=0.
REQ-022 Sum SHALL therefore equal A XOR B during reset.
REQ-023 Reset asserted mid-word SHALL abandon the partial word; the first rising clk after rst falls SHALL process bit 0 of a new word.

Configuration
REQ-024 Macro BSA_OVERFLOW_EN, when defined, SHALL compile in the sticky overflow register.
REQ-025 With BSA_OVERFLOW_EN defined, Ovf SHALL be set on a rising clk when Word_done=1 and majority(A,B,Carry)=1.
REQ-026 Once set, Ovf SHALL remain 1 until rst.
REQ-027 Without BSA_OVERFLOW_EN, Ovf SHALL be tied to constant 0 and no overflow register SHALL be implemented.

Verification
REQ-028 Reset then bits (A,B) = 00,01,10,11,01,11 one per cycle -> Sum = 0,1,1,0,0,1 and Carry before each bit = 0,0,0,0,1,1.
REQ-029 WORD_LEN=8, A=B=1 for 8 cycles -> Sum = 0,1,1,1,1,1,1,1; Word_done high on bit 7; next cycle Carry=0, Bit_cnt=0.
REQ-030 Same stimulus with BSA_OVERFLOW_EN -> Ovf rises after bit 7 and stays 1.
REQ-031 Same stimulus without BSA_OVERFLOW_EN -> Ovf stays 0 throughout.
REQ-032 Build Carry=1 (A=B=1), assert rst between clock edges -> Carry, Bit_cnt and Ovf go to 0 immediately; Sum follows A XOR B.
REQ-033 WORD_LEN=0, A=B=1 for 20 cycles -> Bit_cnt stays 0, Word_done stays 0, Carry stays 1 after the first edge, and Sum=1 from the second bit on.

Source files
------------

// File: rtl/binary_stream_adder_core.sv
// Bit-serial adder, LSB first, with optional word framing (WORD_LEN=0 means unbounded).
// Define BSA_OVERFLOW_EN to build the sticky per-word overflow flag; otherwise Ovf is tied to 0.
module binary_stream_adder_core #(
  parameter int unsigned WORD_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       A,
  input  logic       B,
  output logic       Sum,
  output logic       Carry,
  output logic [7:0] Bit_cnt,
  output logic       Word_done,
  output logic       Ovf
);

  logic carry_out;

  assign carry_out = (A & B) | (A & Carry) | (B & Carry);
  assign Sum       = A ^ B ^ Carry;

  generate
    if (WORD_LEN == 0) begin : g_unbounded
      assign Bit_cnt   = '0;
      assign Word_done = 1'b0;
    end else begin : g_framed
      localparam logic [7:0] LAST = 8'(WORD_LEN - 1);
      logic [7:0] cnt_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q <= '0;
        end else if (cnt_q == LAST) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end

      assign Bit_cnt   = cnt_q;
      assign Word_done = (cnt_q == LAST);
    end
  endgenerate

  // The MSB carry-out is dropped so the next word starts with carry-in 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Carry <= 1'b0;
    end else begin
      Carry <= carry_out & ~Word_done;
    end
  end

`ifdef BSA_OVERFLOW_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Ovf <= 1'b0;
    end else if (Word_done && carry_out) begin
      Ovf <= 1'b1;
    end
  end
`else
  assign Ovf = 1'b0;
`endif

endmodule

// File: tb/tb_binary_stream_adder_core.sv
// Directed bench: a WORD_LEN=8 instance and an unbounded (WORD_LEN=0) instance on shared inputs.
module tb_binary_stream_adder_core;

`ifdef BSA_OVERFLOW_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       A = 1'b0;
  logic       B = 1'b0;
  logic       Sum, Carry, Word_done, Ovf;
  logic [7:0] Bit_cnt;
  logic       Sum0, Carry0, Word_done0, Ovf0;
  logic [7:0] Bit_cnt0;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  binary_stream_adder_core #(.WORD_LEN(8)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .Sum(Sum), .Carry(Carry),
    .Bit_cnt(Bit_cnt), .Word_done(Word_done), .Ovf(Ovf)
  );

  binary_stream_adder_core #(.WORD_LEN(0)) dut0 (
    .clk(clk), .rst(rst), .A(A), .B(B), .Sum(Sum0), .Carry(Carry0),
    .Bit_cnt(Bit_cnt0), .Word_done(Word_done0), .Ovf(Ovf0)
  );

  always #5 clk = ~clk;

  // Observed tuple is {Sum, Carry, Bit_cnt, Word_done, Ovf}.
  task automatic test_reset();
    logic [11:0] exp, got;
    @(negedge clk);
    rst = 1'b1; A = 1'b0; B = 1'b1;
    #1;
    exp = {1'b1, 1'b0, 8'd0, 1'b0, 1'b0};
    got = {Sum, Carry, Bit_cnt, Word_done, Ovf};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL reset: got %h expected %h", got, exp);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [1:0] ab [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b11};
    logic       es [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       ec [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [11:0] exp, got;
    for (int i = 0; i < 6; i++) begin
      {A, B} = ab[i];
      #1;
      exp = {es[i], ec[i], 8'(i), 1'b0, 1'b0};
      got = {Sum, Carry, Bit_cnt, Word_done, Ovf};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL basic bit %0d: got %h expected %h", i, got, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_word8();
    logic [11:0] exp, got;
    logic [7:0]  es = 8'b1111_1110;
    test_reset();
    for (int i = 0; i < 8; i++) begin
      A = 1'b1; B = 1'b1;
      #1;
      exp = {es[i], (i != 0), 8'(i), (i == 7), 1'b0};
      got = {Sum, Carry, Bit_cnt, Word_done, Ovf};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL word8 bit %0d: got %h expected %h", i, got, exp);
      end
      @(negedge clk);
    end
    // Ovf must persist through a following word with no carry.
    for (int i = 0; i < 3; i++) begin
      A = 1'b0; B = 1'b0;
      #1;
      exp = {1'b0, 1'b0, 8'(i), 1'b0, OVF_EN};
      got = {Sum, Carry, Bit_cnt, Word_done, Ovf};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL word8 after bit %0d: got %h expected %h", i, got, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  wa [2] = '{8'h96, 8'h21};
    logic [7:0]  wb [2] = '{8'h7D, 8'h34};
    logic [7:0]  ws [2] = '{8'h13, 8'h55};
    logic [7:0]  a_w, b_w, s_w;
    logic [11:0] exp, got;
    logic        ovf_exp;
    test_reset();
    for (int w = 0; w < 2; w++) begin
      a_w = wa[w]; b_w = wb[w]; s_w = ws[w];
      ovf_exp = OVF_EN && (w == 1);
      for (int i = 0; i < 8; i++) begin
        A = a_w[i]; B = b_w[i];
        #1;
        exp = {s_w[i], 1'b0, 8'(i), (i == 7), ovf_exp};
        got = {Sum, 1'b0, Bit_cnt, Word_done, Ovf};
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("FAIL b2b word %0d bit %0d: got %h expected %h", w, i, got, exp);
        end
        @(negedge clk);
      end
    end
    #1;
    vectors++;
    if ({Carry, Bit_cnt, Ovf} !== {1'b0, 8'd0, OVF_EN}) begin
      miscompares++;
      $display("FAIL b2b end: got %h expected %h", {Carry, Bit_cnt, Ovf}, {1'b0, 8'd0, OVF_EN});
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] exp, got;
    @(negedge clk);
    A = 1'b1; B = 1'b1;
    @(negedge clk);
    A = 1'b1; B = 1'b1;
    @(negedge clk);
    #1;
    exp = {1'b1, 1'b1, 8'd3, 1'b0, OVF_EN};
    got = {Sum, Carry, Bit_cnt, Word_done, Ovf};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL midreset pre: got %h expected %h", got, exp);
    end
    #1 rst = 1'b1;
    #1;
    exp = {1'b0, 1'b0, 8'd0, 1'b0, 1'b0};
    got = {Sum, Carry, Bit_cnt, Word_done, Ovf};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL midreset async: got %h expected %h", got, exp);
    end
    A = 1'b1; B = 1'b0;
    #1;
    vectors++;
    if (Sum !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset sum: got %b expected 1", Sum);
    end
    @(negedge clk);
    rst = 1'b0; A = 1'b1; B = 1'b1;
    @(negedge clk);
    #1;
    exp = {1'b1, 1'b1, 8'd1, 1'b0, 1'b0};
    got = {Sum, Carry, Bit_cnt, Word_done, Ovf};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL midreset restart: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_unbounded();
    logic [11:0] exp, got;
    test_reset();
    for (int i = 0; i < 20; i++) begin
      A = 1'b1; B = 1'b1;
      #1;
      exp = {(i != 0), (i != 0), 8'd0, 1'b0, 1'b0};
      got = {Sum0, Carry0, Bit_cnt0, Word_done0, Ovf0};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL unbounded bit %0d: got %h expected %h", i, got, exp);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_word8();
    test_back_to_back();
    test_reset_mid();
    test_unbounded();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
